// File: rtl/frame_buffer_scheduler.sv
// Triple-buffer scheduler: rotates three SDRAM frame buffers between the camera
// writer and the host reader, publishing the newest completed frame with an irq.
module frame_buffer_scheduler #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] FRAME_BYTES = 32'h0009_6000,
    parameter int          DROP_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_frame_done,
    input  logic              wr_frame_error,
    output logic [31:0]       wr_base_addr,
    input  logic              read_done,
    output logic [31:0]       current_frame,
    output logic              frame_rdy_irq,
    output logic [31:0]       frame_count,
    output logic [DROP_W-1:0] drop_count
);

    localparam logic [31:0] ADDR0 = BASE_ADDR;
    localparam logic [31:0] ADDR1 = BASE_ADDR + FRAME_BYTES;
    localparam logic [31:0] ADDR2 = BASE_ADDR + (FRAME_BYTES << 1);

    typedef enum logic {
        IDLE,
        HELD
    } state_t;

    state_t state, state_next;

    logic [1:0] w_buf, r_buf, h_buf;
    logic [1:0] w_buf_next, r_buf_next, h_buf_next;
    logic       ready_valid, ready_valid_next;
    logic       done_accepted;
    logic       handoff;
    logic [31:0] wr_base_next;
    logic [31:0] current_next;
    logic        irq_next;
    logic [31:0] frame_count_next;
    logic [DROP_W-1:0] drop_count_next;

    function automatic logic [31:0] addr_of(input logic [1:0] idx);
        case (idx)
            2'd1:    addr_of = ADDR1;
            2'd2:    addr_of = ADDR2;
            default: addr_of = ADDR0;
        endcase
    endfunction

    // An error pulse cancels a simultaneous done; a done pulse defers the reader
    // handoff by one cycle so the reader picks up the frame just finished.
    assign done_accepted = wr_frame_done && !wr_frame_error;
    assign handoff       = (state == IDLE) && ready_valid && !wr_frame_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (handoff)   state_next = HELD;
            HELD: if (read_done) state_next = IDLE;
            default:             state_next = IDLE;
        endcase
    end

    // Writer swaps W/R; the handoff swaps R/H. They never coincide, so H is safe.
    always_comb begin
        w_buf_next       = w_buf;
        r_buf_next       = r_buf;
        h_buf_next       = h_buf;
        ready_valid_next = ready_valid;
        wr_base_next     = wr_base_addr;
        current_next     = current_frame;
        irq_next         = frame_rdy_irq;
        frame_count_next = frame_count;
        drop_count_next  = drop_count;

        if (done_accepted) begin
            w_buf_next       = r_buf;
            r_buf_next       = w_buf;
            ready_valid_next = 1'b1;
            wr_base_next     = addr_of(r_buf);
            frame_count_next = frame_count + 32'd1;
            if (ready_valid && (drop_count != {DROP_W{1'b1}})) begin
                drop_count_next = drop_count + 1'b1;
            end
        end else if (handoff) begin
            r_buf_next       = h_buf;
            h_buf_next       = r_buf;
            ready_valid_next = 1'b0;
            current_next     = addr_of(r_buf);
        end

        if (handoff) begin
            irq_next = 1'b1;
        end else if ((state == HELD) && read_done) begin
            irq_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_buf         <= 2'd0;
            r_buf         <= 2'd1;
            h_buf         <= 2'd2;
            ready_valid   <= 1'b0;
            wr_base_addr  <= ADDR0;
            current_frame <= ADDR2;
            frame_rdy_irq <= 1'b0;
            frame_count   <= 32'd0;
            drop_count    <= '0;
        end else begin
            w_buf         <= w_buf_next;
            r_buf         <= r_buf_next;
            h_buf         <= h_buf_next;
            ready_valid   <= ready_valid_next;
            wr_base_addr  <= wr_base_next;
            current_frame <= current_next;
            frame_rdy_irq <= irq_next;
            frame_count   <= frame_count_next;
            drop_count    <= drop_count_next;
        end
    end

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Bench for frame_buffer_scheduler: directed scenarios plus random pulse traffic,
// all compared against a buffer-ownership model kept in the bench.
module tb_frame_buffer_scheduler;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] FRAME = 32'h0009_6000;
    localparam int          DW    = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_frame_done = 1'b0;
    logic          wr_frame_error = 1'b0;
    logic          read_done = 1'b0;
    logic [31:0]   wr_base_addr;
    logic [31:0]   current_frame;
    logic          frame_rdy_irq;
    logic [31:0]   frame_count;
    logic [DW-1:0] drop_count;

    int checks = 0;
    int failures = 0;

    // Model: which physical buffer each party owns, plus pending/held flags.
    int          m_writer, m_ready, m_reader;
    bit          m_pending, m_held;
    logic [31:0] m_frames;
    int          m_drops;

    always #5 clk = ~clk;

    frame_buffer_scheduler #(
        .BASE_ADDR(BASE),
        .FRAME_BYTES(FRAME),
        .DROP_W(DW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wr_frame_done(wr_frame_done),
        .wr_frame_error(wr_frame_error),
        .wr_base_addr(wr_base_addr),
        .read_done(read_done),
        .current_frame(current_frame),
        .frame_rdy_irq(frame_rdy_irq),
        .frame_count(frame_count),
        .drop_count(drop_count)
    );

    function automatic logic [31:0] buf_addr(input int idx);
        logic [31:0] a;
        a = BASE + FRAME * idx;
        return a;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_writer  = 0;
        m_ready   = 1;
        m_reader  = 2;
        m_pending = 0;
        m_held    = 0;
        m_frames  = 0;
        m_drops   = 0;
    endtask

    task automatic modelStep(input bit d, input bit e, input bit rd, input bit rst);
        int  t;
        bit  accept, give;
        if (rst) begin
            modelReset();
        end else begin
            accept = d && !e;
            give   = !m_held && m_pending && !d;
            if (m_held && rd) m_held = 0;
            if (accept) begin
                t = m_writer; m_writer = m_ready; m_ready = t;
                if (m_pending && m_drops < (1 << DW) - 1) m_drops++;
                m_pending = 1;
                m_frames  = m_frames + 1;
            end else if (give) begin
                t = m_ready; m_ready = m_reader; m_reader = t;
                m_pending = 0;
                m_held    = 1;
            end
        end
    endtask

    task automatic applyStimulus(input bit d, input bit e, input bit rd, input bit rst);
        @(negedge clk);
        wr_frame_done  = d;
        wr_frame_error = e;
        read_done      = rd;
        reset          = rst;
        @(posedge clk);
        modelStep(d, e, rd, rst);
        #1;
        wr_frame_done  = 1'b0;
        wr_frame_error = 1'b0;
        read_done      = 1'b0;
        reset          = 1'b0;
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, ".wr_base"}, wr_base_addr, buf_addr(m_writer));
        checkOutput({tag, ".current"}, current_frame, buf_addr(m_reader));
        checkOutput({tag, ".irq"}, {31'd0, frame_rdy_irq}, {31'd0, m_held});
        checkOutput({tag, ".frames"}, frame_count, m_frames);
        checkOutput({tag, ".drops"}, {16'd0, drop_count}, m_drops);
        checkOutput({tag, ".distinct"}, {31'd0, wr_base_addr != current_frame}, 32'd1);
    endtask

    initial begin
        modelReset();
        applyStimulus(0, 0, 0, 1);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0);
        checkOutput("reset.wr_base", wr_base_addr, 32'h0);
        checkOutput("reset.current", current_frame, 32'h12C000);
        checkOutput("reset.irq", {31'd0, frame_rdy_irq}, 32'd0);
        checkOutput("reset.frames", frame_count, 32'd0);
        checkOutput("reset.drops", {16'd0, drop_count}, 32'd0);

        applyStimulus(1, 0, 0, 0);
        checkOutput("single.wr_base", wr_base_addr, 32'h96000);
        checkOutput("single.frames", frame_count, 32'd1);
        checkOutput("single.irq_t1", {31'd0, frame_rdy_irq}, 32'd0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("single.irq_t2", {31'd0, frame_rdy_irq}, 32'd1);
        checkOutput("single.current", current_frame, 32'h0);
        checkModel("single");

        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0);
        checkOutput("drop.count", {16'd0, drop_count}, 32'd2);
        checkModel("drop");
        applyStimulus(0, 0, 1, 0);
        checkOutput("drop.irq_low", {31'd0, frame_rdy_irq}, 32'd0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("drop.irq_high", {31'd0, frame_rdy_irq}, 32'd1);
        checkOutput("drop.current", current_frame, 32'h96000);
        checkModel("drop2");

        applyStimulus(1, 0, 1, 0);
        checkOutput("simul.irq_t1", {31'd0, frame_rdy_irq}, 32'd0);
        checkModel("simul1");
        applyStimulus(0, 0, 0, 0);
        checkOutput("simul.irq_t2", {31'd0, frame_rdy_irq}, 32'd1);
        checkOutput("simul.current", current_frame, 32'h12C000);
        checkModel("simul2");

        applyStimulus(0, 1, 0, 0);
        checkOutput("err.wr_base", wr_base_addr, 32'h0);
        checkOutput("err.frames", frame_count, 32'd5);
        checkOutput("err.irq", {31'd0, frame_rdy_irq}, 32'd1);
        applyStimulus(1, 1, 0, 0);
        checkOutput("errdone.wr_base", wr_base_addr, 32'h0);
        checkOutput("errdone.frames", frame_count, 32'd5);
        checkOutput("errdone.irq", {31'd0, frame_rdy_irq}, 32'd1);
        checkModel("err");

        applyStimulus(1, 0, 1, 1);
        checkOutput("midrst.wr_base", wr_base_addr, 32'h0);
        checkOutput("midrst.current", current_frame, 32'h12C000);
        checkOutput("midrst.irq", {31'd0, frame_rdy_irq}, 32'd0);
        checkOutput("midrst.frames", frame_count, 32'd0);
        checkOutput("midrst.drops", {16'd0, drop_count}, 32'd0);

        for (int i = 0; i < 12000; i++) begin
            applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 999) == 0);
            checkModel("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
